deconvolve: RTL and testbench

Sequential 8-tap inverse of the `convolve` block. It accepts a 15-sample 4-bit sequence y, streamed one sample per handshake, together with the 8 taps h. It recovers the 8 input samples x such that convolve(x, h) = y modulo 16, using iterative long division with one multiply-subtract per cycle. Samples y[8..14] are used only for a consistency check. The block sits downstream of a convolve stage, for channel equalisation and self-test.

---
 rtl/deconvolve.sv | 165 ++++++++++++++++
 tb/tb_deconvolve.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deconvolve.sv
// deconvolve: sequential 8-tap inverse of convolve, 4-bit mod-16 arithmetic.
// Ports: clk/rst_n, start+h_flat (taps), y_in/y_valid/y_ready stream in,
//        x_out/x_valid/x_ready stream out, busy, done, err_h, mismatch.
module deconvolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] h_flat,
  input  logic [3:0]  y_in,
  input  logic        y_valid,
  output logic        y_ready,
  output logic [3:0]  x_out,
  output logic        x_valid,
  input  logic        x_ready,
  output logic        busy,
  output logic        done,
  output logic        err_h,
  output logic        mismatch
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RECV, MAC, RES, OUT, FIN
  } state_t;

  state_t state_q, state_d;

  logic [7:0][3:0] h_q, h_d;
  logic [7:0][3:0] x_q, x_d;
  logic [3:0]      inv_q, inv_d;
  logic [3:0]      n_q, n_d;
  logic [3:0]      acc_q, acc_d;
  logic [2:0]      k_q, k_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic [2:0] k_lo;
  logic [2:0] k_hi;
  logic [2:0] x_idx;
  logic [3:0] prod;
  logic [3:0] res;

  function automatic logic [3:0] inv_of(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'd1:    r = 4'd1;
      4'd3:    r = 4'd11;
      4'd5:    r = 4'd13;
      4'd7:    r = 4'd7;
      4'd9:    r = 4'd9;
      4'd11:   r = 4'd3;
      4'd13:   r = 4'd5;
      4'd15:   r = 4'd15;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Tap window for sample n: k runs max(1,n-7) .. min(n,7).
  assign k_lo  = (n_q >= 4'd8) ? 3'(n_q - 4'd7) : 3'd1;
  assign k_hi  = (n_q >= 4'd7) ? 3'd7 : n_q[2:0];
  assign x_idx = 3'(n_q - {1'b0, k_q});
  assign prod  = h_q[k_q] * x_q[x_idx];
  assign res   = acc_q * inv_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    x_d     = x_q;
    inv_d   = inv_q;
    n_d     = n_q;
    acc_d   = acc_q;
    k_d     = k_q;
    err_d   = err_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          h_d     = h_flat;
          n_d     = 4'd0;
          x_d     = '0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!h_q[0][0]) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          inv_d   = inv_of(h_q[0]);
          state_d = RECV;
        end
      end
      RECV: begin
        if (y_valid) begin
          acc_d   = y_in;
          k_d     = k_lo;
          state_d = (n_q == 4'd0) ? RES : MAC;
        end
      end
      MAC: begin
        acc_d = acc_q - prod;
        k_d   = k_q + 3'd1;
        if (k_q == k_hi) state_d = RES;
      end
      RES: begin
        if (n_q < 4'd8) begin
          x_d[n_q[2:0]] = res;
          state_d       = OUT;
        end else begin
          // Samples past 7 only confirm the recovered x.
          if (acc_q != 4'd0) mis_d = 1'b1;
          if (n_q == 4'd14) begin
            state_d = FIN;
          end else begin
            n_d     = n_q + 4'd1;
            state_d = RECV;
          end
        end
      end
      OUT: begin
        if (x_ready) begin
          n_d     = n_q + 4'd1;
          state_d = RECV;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      x_q     <= '0;
      inv_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      x_q     <= x_d;
      inv_q   <= inv_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign y_ready  = (state_q == RECV);
  assign x_valid  = (state_q == OUT);
  assign x_out    = (state_q == OUT) ? x_q[n_q[2:0]] : 4'd0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err_h    = err_q;
  assign mismatch = mis_q;

endmodule

// File: tb/tb_deconvolve.sv
// tb_deconvolve: randomized self-checking bench for deconvolve against a
// behavioural convolve / long-division model.
module tb_deconvolve;

  typedef logic [7:0][3:0]  vec8_t;
  typedef logic [14:0][3:0] vec15_t;

  logic        clk = 1'b0;
  logic        rst_n, start, y_valid, y_ready, x_valid, x_ready;
  logic        busy, done, err_h, mismatch;
  logic [31:0] h_flat;
  logic [3:0]  y_in, x_out;

  int checks = 0;
  int errors = 0;

  vec8_t got;
  int    nx, done_cnt, done_cyc;
  logic  mis_d, err_d, saw_yr, saw_xv, stable_ok, post_ok;
  int    acc_cyc [15];
  int    xv_cyc  [8];

  deconvolve dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_flat(h_flat),
    .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
    .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready),
    .busy(busy), .done(done), .err_h(err_h), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic vec15_t conv(vec8_t h, vec8_t x);
    vec15_t y;
    int s;
    for (int n = 0; n < 15; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++)
        if (n - k >= 0 && n - k < 8)
          s += int'(h[k]) * int'(x[n-k]);
      y[n] = 4'(s % 16);
    end
    return y;
  endfunction

  function automatic void ref_deconv(input vec8_t h, input vec15_t y,
                                     output vec8_t x, output logic mis);
    int inv, s;
    vec15_t yc;
    inv = 0;
    for (int b = 0; b < 16; b++)
      if ((int'(h[0]) * b) % 16 == 1) inv = b;
    x = '0;
    for (int n = 0; n < 8; n++) begin
      s = int'(y[n]);
      for (int k = 1; k <= n; k++)
        s -= int'(h[k]) * int'(x[n-k]);
      s = ((s % 16) + 16) % 16;
      x[n] = 4'((s * inv) % 16);
    end
    yc = conv(h, x);
    mis = 1'b0;
    for (int n = 8; n < 15; n++)
      if (yc[n] != y[n]) mis = 1'b1;
  endfunction

  function automatic int kmac(int n);
    int lo, hi;
    if (n == 0) return 0;
    lo = (n > 7) ? n - 7 : 1;
    hi = (n < 7) ? n : 7;
    return hi - lo + 1;
  endfunction

  // Drives one run from a negedge; returns at a negedge.
  task automatic run(input logic [31:0] h, input vec15_t yv,
                     input int xr_mode, input int abort_n,
                     input int poke_at);
    int yi, hold;
    logic pend, abort_pend;
    logic [3:0] held;
    yi = 0; hold = 0; pend = 0; abort_pend = 0; held = '0;
    nx = 0; done_cnt = 0; done_cyc = -1; mis_d = 0; err_d = 0;
    saw_yr = 0; saw_xv = 0; stable_ok = 1; post_ok = 0; got = '0;
    for (int i = 0; i < 15; i++) acc_cyc[i] = -100;
    for (int i = 0; i < 8; i++)  xv_cyc[i]  = -100;
    h_flat = h; start = 1; y_valid = 0; x_ready = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (abort_pend) begin
        rst_n = 0; start = 0; y_valid = 0;
        return;
      end
      start  = (cyc == poke_at);
      h_flat = start ? ~h : h;
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        post_ok = !done && !busy;
        y_valid = 0; x_ready = 0;
        return;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; mis_d = mismatch; err_d = err_h;
      end
      if (y_ready) saw_yr = 1;
      y_valid = (yi < 15);
      y_in = (yi < 15) ? yv[yi] : 4'($urandom);
      if (y_ready && y_valid) begin
        acc_cyc[yi] = cyc;
        yi++;
        if (yi == abort_n) abort_pend = 1;
      end
      if (x_valid) begin
        saw_xv = 1;
        if (!pend) begin
          if (nx < 8) xv_cyc[nx] = cyc;
          held = x_out; pend = 1;
        end else if (x_out !== held) stable_ok = 0;
        if (y_ready) stable_ok = 0;
        case (xr_mode)
          1: begin
            x_ready = !(nx == 0 && hold < 5);
            if (!x_ready) hold++;
          end
          2: x_ready = ($urandom_range(0, 3) != 0);
          default: x_ready = 1;
        endcase
        if (x_ready) begin
          if (nx < 8) got[nx] = x_out;
          nx++; pend = 0;
        end
      end else begin
        x_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({y_ready, x_valid, x_out, busy, done, err_h, mismatch} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {y_ready, x_valid, x_out, busy, done, err_h, mismatch});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    vec8_t h, xe;
    vec15_t y;
    int lat_bad;
    h = '0; h[0] = 4'd1;
    xe = {4'd8, 4'd3, 4'd15, 4'd0, 4'd7, 4'd2, 4'd9, 4'd5};
    y = '0; y[7:0] = xe;
    run(h, y, 0, -1, -1);
    checks++;
    if (got !== xe || nx != 8) begin
      errors++; $display("FAIL identity_x: got %h n=%0d want %h", got, nx, xe);
    end
    checks++;
    if (done_cnt != 1 || mis_d !== 1'b0 || !post_ok) begin
      errors++;
      $display("FAIL identity_done: done=%0d mis=%b post=%b want 1 0 1",
               done_cnt, mis_d, post_ok);
    end
    lat_bad = 0;
    for (int n = 0; n < 8; n++)
      if (xv_cyc[n] - acc_cyc[n] != kmac(n) + 2) lat_bad++;
    checks++;
    if (lat_bad != 0) begin
      errors++; $display("FAIL identity_latency: got %0d bad want 0", lat_bad);
    end
    checks++;
    if (done_cyc - acc_cyc[14] != 3) begin
      errors++;
      $display("FAIL done_timing: got %0d want 3", done_cyc - acc_cyc[14]);
    end
  endtask

  task automatic test_two_tap();
    vec8_t h, xe;
    vec15_t y;
    h = '0; h[0] = 4'd1; h[1] = 4'd1;
    y = '0; y[0] = 4'd1; y[1] = 4'd3; y[2] = 4'd2;
    xe = '0; xe[0] = 4'd1; xe[1] = 4'd2;
    run(h, y, 2, -1, -1);
    checks++;
    if (got !== xe || mis_d !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL two_tap: got %h mis=%b done=%0d want %h 0 1",
               got, mis_d, done_cnt, xe);
    end
  endtask

  task automatic test_inverse();
    vec8_t h, xe;
    vec15_t y;
    h = '0; h[0] = 4'd3;
    y = '0; y[0] = 4'd3; y[1] = 4'd6;
    xe = '0; xe[0] = 4'd1; xe[1] = 4'd2;
    run(h, y, 0, -1, -1);
    checks++;
    if (got !== xe || mis_d !== 1'b0) begin
      errors++; $display("FAIL inverse: got %h mis=%b want %h 0", got, mis_d, xe);
    end
  endtask

  task automatic test_non_invertible();
    vec8_t h;
    vec15_t y;
    h = vec8_t'($urandom); h[0] = 4'd2;
    y = vec15_t'({$urandom, $urandom});
    run(h, y, 0, -1, -1);
    checks++;
    if (done_cyc != 2 || err_d !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL err_h_path: done_cyc=%0d err=%b want 2 1", done_cyc, err_d);
    end
    checks++;
    if (saw_yr || saw_xv || err_h !== 1'b1) begin
      errors++;
      $display("FAIL err_h_quiet: yr=%b xv=%b sticky=%b want 0 0 1",
               saw_yr, saw_xv, err_h);
    end
  endtask

  task automatic test_mismatch_backpressure();
    vec8_t h, xe;
    vec15_t y;
    h = '0; h[0] = 4'd1;
    xe = vec8_t'($urandom);
    y = '0; y[7:0] = xe; y[8] = 4'd1;
    run(h, y, 1, -1, -1);
    checks++;
    if (got !== xe || !stable_ok) begin
      errors++;
      $display("FAIL backpressure: got %h stable=%b want %h 1", got, stable_ok, xe);
    end
    checks++;
    if (mis_d !== 1'b1 || mismatch !== 1'b1 || err_d !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_flag: done=%b now=%b err=%b want 1 1 0",
               mis_d, mismatch, err_d);
    end
  endtask

  task automatic test_reset_mid();
    vec8_t h, xe;
    vec15_t y;
    h = vec8_t'($urandom); h[0][0] = 1'b1;
    xe = vec8_t'($urandom);
    y = conv(h, xe);
    run(h, y, 0, 11, -1);
    @(negedge clk);
    checks++;
    if ({y_ready, x_valid, x_out, busy, done, err_h, mismatch} !== 10'd0 ||
        done_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid: got %b done=%0d want 0 0",
               {y_ready, x_valid, x_out, busy, done, err_h, mismatch}, done_cnt);
    end
    rst_n = 1;
    @(negedge clk);
    run(h, y, 0, -1, -1);
    checks++;
    if (got !== xe || done_cnt != 1) begin
      errors++; $display("FAIL after_reset: got %h want %h", got, xe);
    end
  endtask

  task automatic test_start_busy();
    vec8_t h, xe;
    vec15_t y;
    h = vec8_t'($urandom); h[0][0] = 1'b1;
    xe = vec8_t'($urandom);
    y = conv(h, xe);
    run(h, y, 2, -1, 6);
    checks++;
    if (got !== xe || done_cnt != 1 || mis_d !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got %h done=%0d want %h 1", got, done_cnt, xe);
    end
  endtask

  task automatic test_back_to_back();
    vec8_t h, xe, xr;
    vec15_t y;
    logic me;
    for (int i = 0; i < 8; i++) begin
      h = vec8_t'($urandom); h[0][0] = 1'b1;
      if (i < 5) begin
        xe = vec8_t'($urandom);
        y = conv(h, xe);
      end else begin
        y = vec15_t'({$urandom, $urandom});
      end
      ref_deconv(h, y, xr, me);
      run(h, y, 2, -1, -1);
      checks++;
      if (got !== xr || mis_d !== me || done_cnt != 1 || nx != 8) begin
        errors++;
        $display("FAIL random_%0d: got %h mis=%b want %h %b",
                 i, got, mis_d, xr, me);
      end
    end
  endtask

  initial begin
    rst_n = 0; start = 0; y_valid = 0; x_ready = 0;
    y_in = '0; h_flat = '0;
    test_reset();
    test_identity();
    test_two_tap();
    test_inverse();
    test_non_invertible();
    test_mismatch_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
